// File: rtl/monolith_pkg.sv
// Shared field definitions for the Monolith sponge front end and permutation engine.
// Arithmetic is over GF(2^31 - 1); the all-ones encoding of zero is folded to 0.
package monolith_pkg;

    localparam int FIELD_W = 31;
    localparam logic [FIELD_W-1:0] P = {FIELD_W{1'b1}};

    typedef logic [FIELD_W-1:0] elem_t;

    typedef enum logic [1:0] {
        IDLE,
        ABSORB,
        PERMUTE,
        SQUEEZE
    } sponge_state_e;

    function automatic elem_t add_mod(input elem_t a, input elem_t b);
        logic [FIELD_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= {1'b0, P}) begin
            sum = sum - {1'b0, P};
        end
        // P itself is a second encoding of zero
        if (sum[FIELD_W-1:0] == P) begin
            return '0;
        end
        return sum[FIELD_W-1:0];
    endfunction

endpackage

// File: rtl/monolith_hash.sv
// Iterative permutation engine: loads state_in on the first cycle out of reset,
// runs ROUNDS rounds, then presents state_out with valid for one cycle and restarts.
module monolith_hash
    import monolith_pkg::*;
#(
    parameter int STATE_W = 16,
    parameter int ROUNDS  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [STATE_W*FIELD_W-1:0] state_in,
    output logic [STATE_W*FIELD_W-1:0] state_out,
    output logic                       valid
);

    localparam int CNT_W = $clog2(ROUNDS + 2);

    elem_t            s     [STATE_W];
    elem_t            brick [STATE_W];
    elem_t            mixed [STATE_W];
    logic [CNT_W-1:0] cnt;

    function automatic elem_t sq_mod(input elem_t a);
        logic [2*FIELD_W-1:0] x;
        logic [FIELD_W:0]     fold;
        logic [FIELD_W:0]     red;
        x    = {{FIELD_W{1'b0}}, a} * {{FIELD_W{1'b0}}, a};
        fold = {1'b0, x[FIELD_W-1:0]} + {1'b0, x[2*FIELD_W-1:FIELD_W]};
        red  = {1'b0, fold[FIELD_W-1:0]} + {{FIELD_W{1'b0}}, fold[FIELD_W]};
        if (red >= {1'b0, P}) begin
            red = red - {1'b0, P};
        end
        return red[FIELD_W-1:0];
    endfunction

    // One round: square-feed each lane from its predecessor, then add the
    // circular neighbour and a round constant.
    always_comb begin
        int rnd;
        rnd = int'(cnt) - 1;
        brick[0] = s[0];
        for (int i = 1; i < STATE_W; i++) begin
            brick[i] = add_mod(s[i], sq_mod(s[i-1]));
        end
        for (int i = 0; i < STATE_W; i++) begin
            mixed[i] = add_mod(add_mod(brick[i], brick[(i+1) % STATE_W]),
                               elem_t'(rnd * STATE_W + i + 1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (cnt == '0) begin
            for (int i = 0; i < STATE_W; i++) begin
                s[i] <= state_in[i*FIELD_W +: FIELD_W];
            end
            cnt <= CNT_W'(1);
        end else if (cnt == CNT_W'(ROUNDS + 1)) begin
            cnt <= '0;
        end else begin
            for (int i = 0; i < STATE_W; i++) begin
                s[i] <= mixed[i];
            end
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_comb begin
        for (int i = 0; i < STATE_W; i++) begin
            state_out[i*FIELD_W +: FIELD_W] = s[i];
        end
    end

    assign valid = (cnt == CNT_W'(ROUNDS + 1));

endmodule

// File: rtl/monolith_sponge.sv
// Streaming sponge / compression front end around the monolith_hash permutation:
// absorbs with field addition and 10* padding, permutes as needed, squeezes OUT_LEN lanes.
module monolith_sponge
    import monolith_pkg::*;
#(
    parameter int ELEM_W  = 31,
    parameter int STATE_W = 16,
    parameter int RATE    = 8,
    parameter int OUT_LEN = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ELEM_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ELEM_W-1:0] out_data,
    output logic              out_last,
    output logic              busy
);

    localparam int CW = $clog2(STATE_W);

    sponge_state_e             state, next_state;
    elem_t                     st [STATE_W];
    logic [CW-1:0]             cnt, idx;
    logic                      pad_pending, msg_end, mode_q;
    logic                      in_fire, out_fire, mode_cur, blk_done;
    logic [STATE_W*ELEM_W-1:0] eng_in, eng_out;
    logic                      eng_rst, eng_valid;

    assign in_ready  = (state == IDLE || state == ABSORB) && !reset;
    assign out_valid = (state == SQUEEZE) && !reset;
    assign busy      = (state != IDLE) && !reset;
    assign out_data  = out_valid ? st[idx] : '0;
    assign out_last  = out_valid && (idx == CW'(OUT_LEN - 1));

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    // mode is only sampled with the first element of a message
    assign mode_cur = (state == IDLE) ? mode : mode_q;
    assign blk_done = in_last || (mode_cur ? (cnt == CW'(2 * OUT_LEN - 1))
                                           : (cnt == CW'(RATE - 1)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_fire) next_state = blk_done ? PERMUTE : ABSORB;
            ABSORB:  if (in_fire && blk_done) next_state = PERMUTE;
            PERMUTE: if (eng_valid) next_state = pad_pending ? PERMUTE
                                               : (msg_end ? SQUEEZE : ABSORB);
            SQUEEZE: if (out_fire && out_last) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < STATE_W; i++) st[i] <= '0;
            cnt         <= '0;
            idx         <= '0;
            pad_pending <= 1'b0;
            msg_end     <= 1'b0;
            mode_q      <= 1'b0;
        end else begin
            case (state)
                IDLE, ABSORB: begin
                    if (in_fire) begin
                        if (state == IDLE) mode_q <= mode;
                        if (mode_cur) begin
                            st[cnt] <= add_mod('0, elem_t'(in_data));
                        end else begin
                            st[cnt] <= add_mod(st[cnt], elem_t'(in_data));
                            // 10* padding lands in the next lane, or in a follow-up block
                            if (in_last && cnt != CW'(RATE - 1)) begin
                                st[cnt + CW'(1)] <= add_mod(st[cnt + CW'(1)], elem_t'(1));
                            end
                            if (in_last && cnt == CW'(RATE - 1)) pad_pending <= 1'b1;
                        end
                        if (blk_done) begin
                            cnt     <= '0;
                            msg_end <= in_last || mode_cur;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                PERMUTE: begin
                    if (eng_valid) begin
                        for (int i = 0; i < STATE_W; i++) begin
                            st[i] <= eng_out[i*ELEM_W +: ELEM_W];
                        end
                        if (pad_pending) begin
                            st[0] <= add_mod(eng_out[ELEM_W-1:0], elem_t'(1));
                        end
                        pad_pending <= 1'b0;
                    end
                end
                SQUEEZE: begin
                    if (out_fire) begin
                        if (out_last) begin
                            for (int i = 0; i < STATE_W; i++) st[i] <= '0;
                            idx     <= '0;
                            msg_end <= 1'b0;
                        end else begin
                            idx <= idx + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Engine restarts whenever the FSM leaves PERMUTE; st is frozen while it runs
    assign eng_rst = (state != PERMUTE) || reset;

    always_comb begin
        for (int i = 0; i < STATE_W; i++) begin
            eng_in[i*ELEM_W +: ELEM_W] = st[i];
        end
    end

    monolith_hash #(
        .STATE_W(STATE_W),
        .ROUNDS (4)
    ) u_hash (
        .clk      (clk),
        .reset    (eng_rst),
        .state_in (eng_in),
        .state_out(eng_out),
        .valid    (eng_valid)
    );

endmodule

// File: tb/tb_monolith_sponge.sv
// Directed bench for monolith_sponge: reset behaviour, hash / compress digests against
// a reference permutation model, padding, normalisation and output back-pressure.
module tb_monolith_sponge;
    import monolith_pkg::*;

    localparam longint unsigned PM = 64'h7FFF_FFFF;
    localparam int PERM_CYC = 6;

    logic        clk = 1'b0;
    logic        reset, mode, in_valid, in_ready, in_last;
    logic        out_valid, out_ready, out_last, busy;
    logic [30:0] in_data, out_data;

    int checks = 0;
    int errors = 0;
    int runs   = 0;
    int base;

    longint unsigned ms [16];
    logic [30:0]     expd [4];
    logic [30:0]     got [4];
    logic            gotl [4];
    int              ngot, pcyc, waits;
    logic [30:0]     hold_d;
    logic            hold_l;

    always #5 clk = ~clk;

    monolith_sponge dut (
        .clk      (clk),
        .reset    (reset),
        .mode     (mode),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .busy     (busy)
    );

    always @(posedge clk) begin
        if (!reset && dut.state == PERMUTE && dut.eng_valid) runs <= runs + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference permutation: 4 rounds of square-feed plus circular add and round constant
    task automatic perm_model();
        longint unsigned b [16];
        for (int r = 0; r < 4; r++) begin
            b[0] = ms[0];
            for (int i = 1; i < 16; i++) b[i] = (ms[i] + (ms[i-1] * ms[i-1]) % PM) % PM;
            for (int i = 0; i < 16; i++)
                ms[i] = (b[i] + b[(i+1) % 16] + longint'(r * 16 + i + 1)) % PM;
        end
    endtask

    task automatic take_expect();
        for (int i = 0; i < 4; i++) expd[i] = ms[i][30:0];
    endtask

    task automatic clear_ms();
        for (int i = 0; i < 16; i++) ms[i] = 0;
    endtask

    task automatic send(input logic [30:0] d, input logic l, input logic m);
        logic ok;
        in_valid = 1'b1; in_data = d; in_last = l; mode = m;
        ok = 1'b0; waits = 0;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1; else waits++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_last = 1'b0;
        chk("accept_wait", waits, 0);
    endtask

    task automatic collect();
        ngot = 0; pcyc = 0;
        out_ready = 1'b1;
        for (int t = 0; t < 100 && ngot < 4; t++) begin
            @(negedge clk);
            if (out_valid) begin
                got[ngot] = out_data; gotl[ngot] = out_last; ngot++;
            end else if (ngot == 0) begin
                pcyc++;
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        chk("digest_count", ngot, 4);
    endtask

    task automatic check_digest(input string tag, input int exp_pcyc, input int exp_runs);
        chk({tag, "_latency"}, pcyc, exp_pcyc);
        chk({tag, "_runs"}, runs - base, exp_runs);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_data"}, {1'b0, got[i]}, {1'b0, expd[i]});
            chk({tag, "_last"}, {31'b0, gotl[i]}, {31'b0, (i == 3)});
        end
    endtask

    initial begin
        reset = 1'b1; mode = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);
        chk("idle_busy", busy, 0);
        @(posedge clk); #1;

        // Reset asserted during a permutation
        send(31'd1, 1'b0, 1'b0); send(31'd2, 1'b0, 1'b0); send(31'd3, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        chk("perm_busy", busy, 1);
        chk("perm_in_ready", in_ready, 0);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        chk("rstp_out_valid", out_valid, 0);
        chk("rstp_eng_rst", dut.eng_rst, 1);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("rstp_busy", busy, 0);
        chk("rstp_in_ready", in_ready, 1);
        chk("rstp_out_valid2", out_valid, 0);
        chk("rstp_out_data", out_data, 0);
        chk("rstp_eng_rst2", dut.eng_rst, 1);
        @(posedge clk); #1;

        // Hash 1,2,3: padding lands in lane 3
        clear_ms(); ms[0] = 1; ms[1] = 2; ms[2] = 3; ms[3] = 1;
        perm_model(); take_expect();
        base = runs;
        send(31'd1, 1'b0, 1'b0); send(31'd2, 1'b0, 1'b0); send(31'd3, 1'b1, 1'b0);
        collect();
        check_digest("hash3", PERM_CYC, 1);

        // Hash 1..8: full block, padding needs a second permutation
        clear_ms();
        for (int i = 0; i < 8; i++) ms[i] = longint'(i + 1);
        perm_model(); ms[0] = (ms[0] + 1) % PM; perm_model(); take_expect();
        base = runs;
        for (int i = 1; i <= 8; i++) send(31'(i), i == 8, 1'b0);
        collect();
        check_digest("hash8", 2 * PERM_CYC, 2);

        // Compress 0..7; mode dropped after the first element must be ignored
        clear_ms();
        for (int i = 0; i < 8; i++) ms[i] = longint'(i);
        perm_model(); take_expect();
        base = runs;
        for (int i = 0; i < 8; i++) send(31'(i), i == 7, i == 0);
        collect();
        check_digest("comp", PERM_CYC, 1);

        // Same compression with the all-ones encoding of zero
        base = runs;
        send(31'h7FFF_FFFF, 1'b0, 1'b1);
        for (int i = 1; i < 8; i++) send(31'(i), i == 7, 1'b0);
        collect();
        check_digest("comp_norm", PERM_CYC, 1);

        // Back-pressure on the digest port
        clear_ms(); ms[0] = 1; ms[1] = 2; ms[2] = 3; ms[3] = 1;
        perm_model(); take_expect();
        send(31'd1, 1'b0, 1'b0); send(31'd2, 1'b0, 1'b0); send(31'd3, 1'b1, 1'b0);
        hold_d = '0; hold_l = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (out_valid) begin
                hold_d = out_data; hold_l = out_last;
                break;
            end
            @(posedge clk); #1;
        end
        chk("stall_reach_valid", out_valid, 1);
        in_valid = 1'b1; in_data = 31'd9; in_last = 1'b1; mode = 1'b0;
        for (int t = 0; t < 10; t++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, hold_d);
            chk("stall_last", out_last, hold_l);
            chk("stall_in_ready", in_ready, 0);
        end
        in_valid = 1'b0; in_last = 1'b0;
        @(posedge clk); #1;
        collect();
        chk("stall_first", {1'b0, got[0]}, {1'b0, expd[0]});
        chk("stall_digest3", {1'b0, got[3]}, {1'b0, expd[3]});
        chk("stall_last_flag", gotl[3], 1);
        @(negedge clk);
        chk("after_last_ready", in_ready, 1);
        chk("after_last_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
